fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer between the PC/instruction memory and the IF/ID boundary.
- Owns the fetch PC and drives a req/gnt/rvalid handshake to instruction RAM, with up to DEPTH requests outstanding.
- Buffers returned words with their addresses in a DEPTH-entry FIFO and presents them to ID under a valid/ready handshake.
- Handles branch redirects by flushing buffered and in-flight fetches.

---
 rtl/fetch_ctrl.sv | 101 ++++++++++
 tb/tb_fetch_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer keeping at most DEPTH fetches in flight or buffered
// Ports: clk_i/rst_i clock and synchronous active-high reset; fetch_en_i/boot_addr_i run control
//   and start PC; instr_req_o/instr_addr_o/instr_gnt_i/instr_rvalid_i/instr_rdata_i RAM handshake;
//   branch_i/branch_addr_i redirect; instr_valid_id_o/instr_rdata_id_o/instr_addr_id_o/id_ready_i
//   ID handshake; busy_o high while fetches are owed or buffered.
module fetch_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_en_i,
    input  logic [31:0] boot_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        id_ready_i,
    output logic        instr_valid_id_o,
    output logic [31:0] instr_rdata_id_o,
    output logic [31:0] instr_addr_id_o,
    output logic        busy_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t         r_state;
    logic [31:0]    r_pc;
    logic [CW-1:0]  r_out, r_disc, r_cnt;
    logic [31:0]    r_qa [DEPTH];
    logic [AW-1:0]  r_qw, r_qr;
    logic [31:0]    r_fa [DEPTH];
    logic [31:0]    r_fd [DEPTH];
    logic [AW-1:0]  r_fw, r_fr;
    logic           w_room, w_gnt, w_push, w_pop, w_unused;
    logic [CW-1:0]  w_out_nxt;
    // Room is judged on outstanding plus buffered so every owed response has a FIFO slot.
    assign w_room           = int'(r_out) + int'(r_cnt) < DEPTH;
    assign instr_req_o      = r_state == FETCH && w_room && !branch_i;
    assign instr_addr_o     = r_pc;
    assign w_gnt            = instr_req_o && instr_gnt_i;
    assign w_out_nxt        = r_out + CW'(w_gnt) - CW'(instr_rvalid_i);
    assign w_push           = instr_rvalid_i && r_disc == '0 && !branch_i;
    assign instr_valid_id_o = r_cnt != '0 && !branch_i;
    assign w_pop            = instr_valid_id_o && id_ready_i;
    assign instr_rdata_id_o = r_cnt != '0 ? r_fd[r_fr] : '0;
    assign instr_addr_id_o  = r_cnt != '0 ? r_fa[r_fr] : '0;
    assign busy_o           = r_out != '0 || r_cnt != '0;
    assign w_unused         = ^{boot_addr_i[1:0], branch_addr_i[1:0]};
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_pc    <= {boot_addr_i[31:2], 2'b00};
            r_out   <= '0;
            r_disc  <= '0;
            r_cnt   <= '0;
            r_qw    <= '0;
            r_qr    <= '0;
            r_fw    <= '0;
            r_fr    <= '0;
        end else begin
            // Leaving FETCH uses the post-edge count so a grant in the exit cycle still drains.
            r_state <= r_state == IDLE ? (fetch_en_i ? FETCH : IDLE)
                     : fetch_en_i ? FETCH : (w_out_nxt == '0 ? IDLE : DRAIN);
            r_pc    <= branch_i ? {branch_addr_i[31:2], 2'b00} : w_gnt ? r_pc + 32'd4 : r_pc;
            r_out   <= w_out_nxt;
            // A redirect owes a drop for every response not yet returned, including none this cycle.
            r_disc  <= branch_i ? r_out - CW'(instr_rvalid_i)
                     : r_disc - CW'(instr_rvalid_i && r_disc != '0);
            if (w_gnt) begin
                r_qa[r_qw] <= r_pc;
                r_qw       <= r_qw + 1'b1;
            end
            if (instr_rvalid_i) r_qr <= r_qr + 1'b1;
            if (branch_i) begin
                r_cnt <= '0;
                r_fw  <= '0;
                r_fr  <= '0;
            end else begin
                if (w_push) begin
                    r_fa[r_fw] <= r_qa[r_qr];
                    r_fd[r_fw] <= instr_rdata_i;
                    r_fw       <= r_fw + 1'b1;
                end
                if (w_pop) r_fr <= r_fr + 1'b1;
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end
`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (int'(r_out) + int'(r_cnt) <= DEPTH);
            assert (!(instr_rvalid_i && r_out == '0));
            assert (!(w_push && int'(r_cnt) == DEPTH && !w_pop));
        end
    end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl with an in-order RAM model of programmable latency
module tb_fetch_ctrl;
    localparam logic [31:0] KEY = 32'h5A5A_C3C3;
    logic        clk = 0;
    logic        rst_i = 1;
    logic        fetch_en_i = 0;
    logic [31:0] boot_addr_i = 0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1;
    logic        instr_rvalid_i = 0;
    logic [31:0] instr_rdata_i = 0;
    logic        branch_i = 0;
    logic [31:0] branch_addr_i = 0;
    logic        id_ready_i = 0;
    logic        instr_valid_id_o;
    logic [31:0] instr_rdata_id_o;
    logic [31:0] instr_addr_id_o;
    logic        busy_o;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ram_q[$];
    int          due_q[$];
    int cyc = 0, last_due = 0, lat = 1, tb_out = 0, d = 0;
    bit g_last = 0;

    fetch_ctrl #(.DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst_i), .fetch_en_i(fetch_en_i), .boot_addr_i(boot_addr_i),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
        .branch_i(branch_i), .branch_addr_i(branch_addr_i), .id_ready_i(id_ready_i),
        .instr_valid_id_o(instr_valid_id_o), .instr_rdata_id_o(instr_rdata_id_o),
        .instr_addr_id_o(instr_addr_id_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // RAM: capture grants mid-cycle, answer in order lat cycles later.
    always @(negedge clk) begin
        g_last = 0;
        if (!rst_i && instr_req_o && instr_gnt_i) begin
            d = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            ram_q.push_back(instr_addr_o);
            due_q.push_back(d);
            last_due = d;
            g_last = 1;
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst_i) begin
            ram_q.delete();
            due_q.delete();
            last_due = cyc;
            tb_out = 0;
            instr_rvalid_i = 0;
            instr_rdata_i = 0;
        end else begin
            tb_out = tb_out + int'(g_last) - int'(instr_rvalid_i);
            if (due_q.size() != 0 && due_q[0] <= cyc) begin
                instr_rvalid_i = 1;
                instr_rdata_i = ram_q[0] ^ KEY;
                void'(ram_q.pop_front());
                void'(due_q.pop_front());
            end else begin
                instr_rvalid_i = 0;
                instr_rdata_i = 0;
            end
        end
    end

    // Monitor: every ID handshake must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst_i && instr_valid_id_o && id_ready_i) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_delivery: got addr %h, expected none", instr_addr_id_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("id_addr", instr_addr_id_o, e);
                chk("id_data", instr_rdata_id_o, e ^ KEY);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [31:0] b);
        tick(1);
        rst_i = 1;
        fetch_en_i = 0;
        branch_i = 0;
        id_ready_i = 0;
        instr_gnt_i = 1;
        boot_addr_i = b;
        tick(1);
        exp_q.delete();
        chk("rst_req", {31'b0, instr_req_o}, 0);
        chk("rst_valid", {31'b0, instr_valid_id_o}, 0);
        chk("rst_busy", {31'b0, busy_o}, 0);
        chk("rst_addr", instr_addr_o, {b[31:2], 2'b00});
        chk("rst_id_rdata", instr_rdata_id_o, 0);
        chk("rst_id_addr", instr_addr_id_o, 0);
        rst_i = 0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d entries left, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        tick(1);
        id_ready_i = 0;
    endtask

    task automatic wait_out2(input string name);
        int n = 0;
        while (!(tb_out == 2 && !instr_valid_id_o) && n < 50) begin
            tick(1);
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $display("FAIL %s_out2: outstanding %0d, expected 2", name, tb_out);
        end
    endtask

    initial begin
        int seen;
        // 1: streaming from an unaligned boot address
        do_reset(32'h0000_0083);
        lat = 1;
        for (int i = 0; i < 10; i++) exp_q.push_back(32'h80 + 32'(4 * i));
        fetch_en_i = 1;
        id_ready_i = 1;
        seen = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_valid_id_o) begin
                seen = i;
                break;
            end
        end
        chk("first_valid_latency", 32'(seen), 3);
        wait_empty("stream");

        // 2: ID stall fills the FIFO, then release
        do_reset(32'h0000_0100);
        lat = 1;
        fetch_en_i = 1;
        tick(10);
        @(negedge clk);
        chk("stall_valid", {31'b0, instr_valid_id_o}, 1);
        chk("stall_req", {31'b0, instr_req_o}, 0);
        chk("stall_head_addr", instr_addr_id_o, 32'h100);
        chk("stall_head_data", instr_rdata_id_o, 32'h100 ^ KEY);
        tick(3);
        @(negedge clk);
        chk("stall_hold_addr", instr_addr_id_o, 32'h100);
        chk("stall_hold_data", instr_rdata_id_o, 32'h100 ^ KEY);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        tick(1);
        id_ready_i = 1;
        wait_empty("release");
        // branch while the FIFO is full: buffered words are flushed
        tick(6);
        chk("full_busy", {31'b0, busy_o}, 1);
        exp_q.push_back(32'h3000);
        exp_q.push_back(32'h3004);
        branch_i = 1;
        branch_addr_i = 32'h0000_3003;
        id_ready_i = 1;
        @(negedge clk);
        chk("branch_full_valid", {31'b0, instr_valid_id_o}, 0);
        chk("branch_full_req", {31'b0, instr_req_o}, 0);
        tick(1);
        branch_i = 0;
        wait_empty("branch_full");

        // 3: branch with two responses still owed
        do_reset(32'h0000_0200);
        lat = 3;
        fetch_en_i = 1;
        id_ready_i = 1;
        wait_out2("branch");
        exp_q.push_back(32'h1000);
        exp_q.push_back(32'h1004);
        exp_q.push_back(32'h1008);
        branch_i = 1;
        branch_addr_i = 32'h0000_1002;
        @(negedge clk);
        chk("branch_valid", {31'b0, instr_valid_id_o}, 0);
        chk("branch_req", {31'b0, instr_req_o}, 0);
        tick(1);
        branch_i = 0;
        wait_empty("branch");

        // 4: grant withheld, request and address must hold
        do_reset(32'h0000_0400);
        lat = 1;
        instr_gnt_i = 0;
        fetch_en_i = 1;
        id_ready_i = 1;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_req", {31'b0, instr_req_o}, 1);
            chk("hold_addr", instr_addr_o, 32'h400);
            tick(1);
        end
        exp_q.push_back(32'h400);
        instr_gnt_i = 1;
        tick(1);
        instr_gnt_i = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after_gnt_addr", instr_addr_o, 32'h404);
            tick(1);
        end
        wait_empty("hold");

        // 5: fetch disabled with two owed -> drain to ID, then idle
        do_reset(32'h0000_0500);
        lat = 3;
        fetch_en_i = 1;
        id_ready_i = 1;
        exp_q.push_back(32'h500);
        exp_q.push_back(32'h504);
        wait_out2("drain");
        fetch_en_i = 0;
        wait_empty("drain");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_busy", {31'b0, busy_o}, 0);
            chk("idle_req", {31'b0, instr_req_o}, 0);
            tick(1);
        end
        // reset mid-stream
        lat = 1;
        fetch_en_i = 1;
        tick(6);
        chk("pre_reset_busy", {31'b0, busy_o}, 1);
        do_reset(32'h0000_0600);

        // 6: PC wraps past the top of memory
        do_reset(32'hFFFF_FFFE);
        lat = 1;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        fetch_en_i = 1;
        id_ready_i = 1;
        wait_empty("wrap");
        fetch_en_i = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
